soc_req_arbiter: RTL and testbench

Request-channel arbiter and address decoder in front of the SoC crossbar. Shares one downstream address channel between the AXI masters (core, debug module), decodes each address against the fixed SoC map into a slave index, and widens the ID with the master index. It also tracks outstanding transactions per master, so responses can never reorder across slaves. One instance serves AR and one serves AW.

---
 rtl/soc_req_arbiter_if.sv | 38 +++
 rtl/soc_req_arbiter.sv | 163 ++++++++++++++++
 tb/tb_soc_req_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_req_arbiter_if.sv
// One AR or AW channel at the crossbar: per-master requests, the shared
// downstream request and completion feedback for the outstanding counters.
interface soc_req_arbiter_if #(
  parameter int unsigned NrMasters = 2,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned AddrWidth = 64
);
  localparam int unsigned OutIdWidth = IdWidth + $clog2(NrMasters);

  // Handshake: a request transfers in a cycle where valid and ready are both
  // high. req_ready_o may depend combinationally on req_valid_i. While
  // out_valid_o is high and out_ready_i is low, every out_* signal holds.
  logic [NrMasters-1:0]                req_valid_i;
  logic [NrMasters-1:0]                req_ready_o;
  logic [NrMasters-1:0][AddrWidth-1:0] req_addr_i;
  logic [NrMasters-1:0][IdWidth-1:0]   req_id_i;
  logic                                out_valid_o;
  logic                                out_ready_i;
  logic [AddrWidth-1:0]                out_addr_o;
  logic [OutIdWidth-1:0]               out_id_o;
  logic [3:0]                          out_slave_o;
  logic                                out_decerr_o;
  logic                                cpl_valid_i;
  logic [OutIdWidth-1:0]               cpl_id_i;
  logic                                cnt_err_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_id_i, out_ready_i, cpl_valid_i, cpl_id_i,
    output req_ready_o, out_valid_o, out_addr_o, out_id_o, out_slave_o,
           out_decerr_o, cnt_err_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_id_i, out_ready_i, cpl_valid_i, cpl_id_i,
    input  req_ready_o, out_valid_o, out_addr_o, out_id_o, out_slave_o,
           out_decerr_o, cnt_err_o
  );
endinterface

// File: rtl/soc_req_arbiter.sv
// Round-robin request arbiter with SoC address decode, ID widening and
// per-master outstanding tracking that pins each master to a single slave.
module soc_req_arbiter #(
  parameter int unsigned NrMasters      = 2,
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned NrSlaves       = 9
) (
  input logic             clk_i,
  input logic             rst_i,
  soc_req_arbiter_if.slave bus
);
  localparam int unsigned    MstW     = $clog2(NrMasters);
  localparam int unsigned    OutIdW   = IdWidth + MstW;
  localparam int unsigned    CntW     = $clog2(MaxOutstanding + 1);
  localparam logic [3:0]     ErrSlave = 4'(NrSlaves);
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);

  // Subtract-then-compare keeps the upper bound from wrapping.
  function automatic logic in_region(input logic [63:0] a, input logic [63:0] base,
                                     input logic [63:0] len);
    return (a >= base) && ((a - base) < len);
  endfunction

  function automatic logic [3:0] decode(input logic [AddrWidth-1:0] addr);
    logic [63:0] a;
    a = 64'(addr);
    if (in_region(a, 64'h8000_0000, 64'h4000_0000)) return 4'd0;
    if (in_region(a, 64'h4000_0000, 64'h0000_1000)) return 4'd1;
    if (in_region(a, 64'h3000_0000, 64'h0001_0000)) return 4'd2;
    if (in_region(a, 64'h2000_0000, 64'h0080_0000)) return 4'd3;
    if (in_region(a, 64'h1000_0000, 64'h0000_1000)) return 4'd4;
    if (in_region(a, 64'h0C00_0000, 64'h03FF_FFFF)) return 4'd5;
    if (in_region(a, 64'h0200_0000, 64'h000C_0000)) return 4'd6;
    if (in_region(a, 64'h0001_0000, 64'h0001_0000)) return 4'd7;
    if (in_region(a, 64'h0000_0000, 64'h0000_1000)) return 4'd8;
    return ErrSlave;
  endfunction

  logic [NrMasters-1:0][CntW-1:0] out_cnt_q, out_cnt_d;
  logic [NrMasters-1:0][3:0]      lock_slv_q, lock_slv_d;
  logic [MstW-1:0]                rr_ptr_q, rr_ptr_d;
  logic                           out_valid_q, out_valid_d;
  logic [AddrWidth-1:0]           out_addr_q, out_addr_d;
  logic [OutIdW-1:0]              out_id_q, out_id_d;
  logic [3:0]                     out_slave_q, out_slave_d;
  logic                           out_decerr_q, out_decerr_d;
  logic                           cnt_err_q, cnt_err_d;

  logic [NrMasters-1:0][3:0] req_slv;
  logic [NrMasters-1:0]      eligible;
  logic [NrMasters-1:0]      gnt_oh;
  logic                      gnt_any;
  logic [MstW-1:0]           gnt_idx;
  logic                      accept;
  logic [MstW-1:0]           cpl_mst;

  assign cpl_mst = bus.cpl_id_i[OutIdW-1 -: MstW];

  // A master with requests in flight may only continue to the same slave.
  always_comb begin
    req_slv  = '0;
    eligible = '0;
    for (int m = 0; m < NrMasters; m++) begin
      req_slv[m]  = decode(bus.req_addr_i[m]);
      eligible[m] = bus.req_valid_i[m] && (out_cnt_q[m] < CntMax) &&
                    ((out_cnt_q[m] == '0) || (req_slv[m] == lock_slv_q[m]));
    end
  end

  always_comb begin
    logic [MstW-1:0] cand;
    cand    = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NrMasters; k++) begin
      cand = MstW'((int'(rr_ptr_q) + k) % int'(NrMasters));
      if (!gnt_any && eligible[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // The output register frees in the same cycle it is drained downstream.
  assign accept = gnt_any && (!out_valid_q || bus.out_ready_i) && !rst_i;

  always_comb begin
    gnt_oh = '0;
    for (int m = 0; m < NrMasters; m++) begin
      gnt_oh[m] = accept && (gnt_idx == MstW'(m));
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_addr_d   = out_addr_q;
    out_id_d     = out_id_q;
    out_slave_d  = out_slave_q;
    out_decerr_d = out_decerr_q;
    rr_ptr_d     = rr_ptr_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_addr_d   = bus.req_addr_i[gnt_idx];
      out_id_d     = {gnt_idx, bus.req_id_i[gnt_idx]};
      out_slave_d  = req_slv[gnt_idx];
      out_decerr_d = (req_slv[gnt_idx] == ErrSlave);
      rr_ptr_d     = MstW'((int'(gnt_idx) + 1) % int'(NrMasters));
    end else if (bus.out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // Completion is applied before the accept so a same-cycle pair nets to zero.
  always_comb begin
    out_cnt_d  = out_cnt_q;
    lock_slv_d = lock_slv_q;
    cnt_err_d  = cnt_err_q;
    for (int m = 0; m < NrMasters; m++) begin
      if (bus.cpl_valid_i && (cpl_mst == MstW'(m))) begin
        if (out_cnt_q[m] == '0) cnt_err_d = 1'b1;
        else                    out_cnt_d[m] = out_cnt_d[m] - 1'b1;
      end
      if (gnt_oh[m]) begin
        out_cnt_d[m]  = out_cnt_d[m] + 1'b1;
        lock_slv_d[m] = req_slv[m];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_cnt_q    <= '0;
      lock_slv_q   <= '0;
      rr_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_id_q     <= '0;
      out_slave_q  <= '0;
      out_decerr_q <= 1'b0;
      cnt_err_q    <= 1'b0;
    end else begin
      out_cnt_q    <= out_cnt_d;
      lock_slv_q   <= lock_slv_d;
      rr_ptr_q     <= rr_ptr_d;
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      out_id_q     <= out_id_d;
      out_slave_q  <= out_slave_d;
      out_decerr_q <= out_decerr_d;
      cnt_err_q    <= cnt_err_d;
    end
  end

  assign bus.req_ready_o  = gnt_oh;
  assign bus.out_valid_o  = out_valid_q;
  assign bus.out_addr_o   = out_addr_q;
  assign bus.out_id_o     = out_id_q;
  assign bus.out_slave_o  = out_slave_q;
  assign bus.out_decerr_o = out_decerr_q;
  assign bus.cnt_err_o    = cnt_err_q;
endmodule

// File: tb/tb_soc_req_arbiter.sv
// Bench for soc_req_arbiter: directed scenarios followed by random traffic,
// all outputs compared every cycle against a transaction-level model.
module tb_soc_req_arbiter;
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  soc_req_arbiter_if #(.NrMasters(2), .IdWidth(4), .AddrWidth(64)) bus ();

  soc_req_arbiter #(
    .NrMasters(2), .IdWidth(4), .AddrWidth(64), .MaxOutstanding(8), .NrSlaves(9)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .bus  (bus)
  );

  localparam logic [63:0] RB [9] = '{64'h8000_0000, 64'h4000_0000, 64'h3000_0000,
                                     64'h2000_0000, 64'h1000_0000, 64'h0C00_0000,
                                     64'h0200_0000, 64'h0001_0000, 64'h0000_0000};
  localparam logic [63:0] RL [9] = '{64'h4000_0000, 64'h1000, 64'h1_0000,
                                     64'h80_0000, 64'h1000, 64'h3FF_FFFF,
                                     64'hC_0000, 64'h1_0000, 64'h1000};

  int n_vec = 0;
  int n_err = 0;

  // Reference state, in plain integers.
  int          m_cnt [2] = '{0, 0};
  int          m_lock[2] = '{0, 0};
  int          m_rr  = 0;
  bit          m_ov  = 1'b0;
  bit          m_err = 1'b0;
  bit          m_dec = 1'b0;
  logic [63:0] m_addr = '0;
  logic [4:0]  m_id   = '0;
  logic [3:0]  m_slv  = '0;

  logic [63:0] dec_a [7] = '{64'h8000_0000, 64'hBFFF_FFFF, 64'hC000_0000,
                             64'h0C00_0000, 64'h1000_1000, 64'h0, 64'h1_FFFF};
  int          dec_s [7] = '{0, 0, 9, 5, 9, 8, 7};

  function automatic int ref_decode(input logic [63:0] a);
    for (int s = 0; s < 9; s++) begin
      if (a >= RB[s] && a < RB[s] + RL[s]) return s;
    end
    return 9;
  endfunction

  function automatic logic [1:0] exp_ready();
    logic [1:0] r;
    r = 2'b00;
    if (rst_i || (m_ov && !bus.out_ready_i)) return r;
    for (int k = 0; k < 2; k++) begin
      int c;
      c = (m_rr + k) % 2;
      if (r == 2'b00 && bus.req_valid_i[c] && m_cnt[c] < 8 &&
          (m_cnt[c] == 0 || ref_decode(bus.req_addr_i[c]) == m_lock[c]))
        r[c] = 1'b1;
    end
    return r;
  endfunction

  task automatic model_update();
    logic [1:0] r;
    int g;
    int cm;
    if (rst_i) begin
      m_cnt = '{0, 0}; m_lock = '{0, 0}; m_rr = 0; m_ov = 0; m_err = 0;
      m_addr = '0; m_id = '0; m_slv = '0; m_dec = 0;
      return;
    end
    r = exp_ready();
    g = r[1] ? 1 : 0;
    if (r != 2'b00) begin
      m_ov   = 1'b1;
      m_addr = bus.req_addr_i[g];
      m_id   = {g[0], bus.req_id_i[g]};
      m_slv  = 4'(ref_decode(m_addr));
      m_dec  = (m_slv == 4'd9);
      m_rr   = (g + 1) % 2;
    end else if (bus.out_ready_i) begin
      m_ov = 1'b0;
    end
    if (bus.cpl_valid_i) begin
      cm = int'(bus.cpl_id_i[4]);
      if (m_cnt[cm] == 0) m_err = 1'b1;
      else                m_cnt[cm]--;
    end
    if (r != 2'b00) begin
      m_cnt[g]++;
      m_lock[g] = int'(m_slv);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are already driven for this cycle; check, advance model, clock.
  task automatic step();
    #1;
    chk("req_ready", bus.req_ready_o, exp_ready());
    chk("out_valid", bus.out_valid_o, m_ov);
    chk("out_addr", bus.out_addr_o, m_addr);
    chk("out_id", bus.out_id_o, m_id);
    chk("out_slave", bus.out_slave_o, m_slv);
    chk("out_decerr", bus.out_decerr_o, m_dec);
    chk("cnt_err", bus.cnt_err_o, m_err);
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int m, input bit v, input logic [63:0] a, input logic [3:0] id);
    bus.req_valid_i[m] = v;
    bus.req_addr_i[m]  = a;
    bus.req_id_i[m]    = id;
  endtask

  task automatic idle_inputs();
    drive(0, 1'b0, 64'h0, 4'h0);
    drive(1, 1'b0, 64'h0, 4'h0);
    bus.out_ready_i = 1'b1;
    bus.cpl_valid_i = 1'b0;
    bus.cpl_id_i    = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    int acc;
    int r;
    int cm;
    logic [63:0] a;
    logic [63:0] off;

    idle_inputs();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_out_valid", bus.out_valid_o, 1'b0);
    chk("reset_ready", bus.req_ready_o, 2'b00);
    step();
    rst_i = 1'b0;

    // Decode sweep through master 0, each request completed right after.
    for (int i = 0; i < 7; i++) begin
      drive(0, 1'b1, dec_a[i], 4'(i + 3));
      #1;
      chk("dec_accept", bus.req_ready_o, 2'b01);
      step();
      drive(0, 1'b0, 64'h0, 4'h0);
      bus.cpl_valid_i = 1'b1;
      bus.cpl_id_i    = {1'b0, 4'(i + 3)};
      #1;
      chk("dec_slave", bus.out_slave_o, 64'(dec_s[i]));
      chk("dec_decerr", bus.out_decerr_o, 64'(dec_s[i] == 9));
      chk("dec_id", bus.out_id_o, {1'b0, 4'(i + 3)});
      chk("dec_addr", bus.out_addr_o, dec_a[i]);
      step();
      bus.cpl_valid_i = 1'b0;
    end

    // Round-robin from reset: 0,1,0,1.
    do_reset();
    drive(0, 1'b1, 64'h8000_0040, 4'h5);
    drive(1, 1'b1, 64'h8000_0080, 4'h6);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_grant", bus.req_ready_o, (k % 2 == 1) ? 2'b10 : 2'b01);
      if (k > 0) chk("rr_id", bus.out_id_o, (k % 2 == 1) ? 5'h05 : 5'h16);
      step();
    end

    // Backpressure: one accept, then the output holds.
    idle_inputs();
    step();
    drive(0, 1'b1, 64'h8000_1000, 4'h1);
    drive(1, 1'b1, 64'h8000_2000, 4'h2);
    bus.out_ready_i = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      acc += $countones(bus.req_ready_o);
      if (c > 0) begin
        chk("bp_hold_valid", bus.out_valid_o, 1'b1);
        chk("bp_hold_addr", bus.out_addr_o, 64'h8000_1000);
      end
      step();
    end
    chk("bp_accepts", 64'(acc), 1);
    bus.out_ready_i = 1'b1;
    #1;
    chk("bp_resume", bus.req_ready_o, 2'b10);
    step();

    // Slave lock: master 0 pinned to UART while master 1 proceeds.
    do_reset();
    drive(0, 1'b1, 64'h1000_0010, 4'h1);
    repeat (2) begin
      #1;
      chk("lock_uart", bus.req_ready_o, 2'b01);
      step();
    end
    drive(0, 1'b1, 64'h8000_0000, 4'h2);
    drive(1, 1'b1, 64'h8000_0100, 4'h3);
    #1;
    chk("lock_stall_m0", bus.req_ready_o, 2'b10);
    step();
    drive(1, 1'b0, 64'h0, 4'h0);
    bus.cpl_valid_i = 1'b1;
    bus.cpl_id_i    = 5'h01;
    repeat (2) begin
      #1;
      chk("lock_still_stalled", bus.req_ready_o, 2'b00);
      step();
    end
    bus.cpl_valid_i = 1'b0;
    #1;
    chk("lock_released", bus.req_ready_o, 2'b01);
    step();

    // Outstanding limit of 8.
    do_reset();
    drive(0, 1'b1, 64'h8000_0200, 4'h7);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("lim_accept", bus.req_ready_o, 2'b01);
      step();
    end
    #1;
    chk("lim_ninth_stall", bus.req_ready_o, 2'b00);
    step();
    bus.cpl_valid_i = 1'b1;
    bus.cpl_id_i    = 5'h07;
    #1;
    chk("lim_cpl_cycle", bus.req_ready_o, 2'b00);
    step();
    bus.cpl_valid_i = 1'b0;
    #1;
    chk("lim_after_cpl", bus.req_ready_o, 2'b01);
    step();
    #1;
    chk("lim_full_again", bus.req_ready_o, 2'b00);
    step();

    // Counter underflow error, sticky, then reset mid-burst.
    do_reset();
    bus.cpl_valid_i = 1'b1;
    bus.cpl_id_i    = 5'h10;
    step();
    bus.cpl_valid_i = 1'b0;
    #1;
    chk("err_set", bus.cnt_err_o, 1'b1);
    step();
    step();
    #1;
    chk("err_sticky", bus.cnt_err_o, 1'b1);
    step();
    drive(0, 1'b1, 64'h8000_0300, 4'h9);
    repeat (3) step();
    rst_i = 1'b1;
    #1;
    chk("rst_ready_low", bus.req_ready_o, 2'b00);
    step();
    rst_i = 1'b0;
    drive(0, 1'b0, 64'h0, 4'h0);
    bus.cpl_valid_i = 1'b1;
    bus.cpl_id_i    = 5'h09;
    #1;
    chk("rst_out_valid", bus.out_valid_o, 1'b0);
    chk("rst_err_clear", bus.cnt_err_o, 1'b0);
    step();
    bus.cpl_valid_i = 1'b0;
    #1;
    chk("rst_late_cpl_err", bus.cnt_err_o, 1'b1);
    step();

    // Random traffic.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int m = 0; m < 2; m++) begin
        r = $urandom_range(0, 10);
        if (r < 9) begin
          off = ($urandom_range(0, 3) == 0) ? RL[r] - 64'd1 : 64'($urandom) % RL[r];
          a   = RB[r] + off;
        end else if (r == 9) begin
          a = 64'hC000_0000 + 64'($urandom_range(0, 255));
        end else begin
          a = {$urandom, $urandom};
        end
        drive(m, ($urandom_range(0, 3) != 0), a, 4'($urandom));
      end
      bus.out_ready_i = ($urandom_range(0, 3) != 0);
      bus.cpl_valid_i = ($urandom_range(0, 2) == 0);
      cm = (m_cnt[1] > 0 && (m_cnt[0] == 0 || $urandom_range(0, 1) == 1)) ? 1 : 0;
      bus.cpl_id_i = {cm[0], 4'($urandom)};
      rst_i = ($urandom_range(0, 149) == 0);
      step();
    end
    rst_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
